// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
//   Sequential shift-and-add controller for an unsigned WIDTH x WIDTH multiply.
//   It borrows one external combinational 2*WIDTH-bit adder. The accumulator and
//   the shifted multiplicand are presented to the adder every cycle. On each RUN
//   step the adder sum is taken only when the current multiplier LSB is set.
//
//   Handshake:
//     - start is sampled in IDLE and in DONE, so operations can run back-to-back.
//     - busy is high for the whole of RUN.
//     - done pulses for one cycle when product becomes valid.
//
//   Optional build macro:
//     EARLY_EXIT_EN - finish as soon as the remaining multiplier bits are all
//                     zero. A multiplier of zero then takes a single step.
//                     When the macro is undefined, every operation takes exactly
//                     WIDTH steps.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] adder_in0,
    output logic [2*WIDTH-1:0] adder_in1,
    input  logic [2*WIDTH-1:0] adder_out,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [CW-1:0]     count;

    logic [PW-1:0]     acc_next;
    logic [WIDTH-1:0]  mplier_next;
    logic              finish;

    // The adder always sees the live accumulator and the shifted multiplicand.
    assign adder_in0 = acc;
    assign adder_in1 = mcand;

    // Value of one RUN step, and whether this step is the last one.
    always_comb begin
        acc_next    = mplier[0] ? adder_out : acc;
        mplier_next = mplier >> 1;
`ifdef EARLY_EXIT_EN
        finish      = (count == LAST_STEP) || (mplier_next == '0);
`else
        finish      = (count == LAST_STEP);
`endif
    end

    // Control FSM with its operand, accumulator and result registers.
    // All outputs are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    count  <= count + 1'b1;
                    if (finish) begin
                        product <= acc_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl
//   Randomised and directed bench for shift_add_mult_ctrl.
//
//   The reference model tracks each operation only as "k steps done out of len".
//   From that it derives every expected output:
//     - accumulator:      a * (b mod 2^k)
//     - adder operand 1:  a << k
//     - product:          a * b
//
//   Build with EARLY_EXIT_EN to check the early-finish variant.
module tb_shift_add_mult_ctrl;

    localparam int WIDTH = 4;
    localparam int PW    = 2 * WIDTH;
    localparam int MASK  = (1 << PW) - 1;
`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    // Negedges from the accept edge to the done cycle, for specific multipliers.
    localparam int LAT_FULL = WIDTH + 1;
    localparam int LAT_B3   = EE ? 3 : 5;
    localparam int LAT_B0   = EE ? 2 : 5;
    localparam int LAT_B1   = EE ? 2 : 5;
    localparam int LAT_B4   = EE ? 4 : 5;
    localparam int LAT_B7   = EE ? 4 : 5;
    localparam int LAT_IGN  = EE ? 1 : 3;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          start   = 1'b0;
    logic [WIDTH-1:0] a    = '0;
    logic [WIDTH-1:0] b    = '0;
    logic [PW-1:0] adder_in0, adder_in1, adder_out, product;
    logic          busy, done;

    // External adder: plain modular sum.
    assign adder_out = adder_in0 + adder_in1;

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .adder_in0 (adder_in0),
        .adder_in1 (adder_in1),
        .adder_out (adder_out),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Number of RUN steps an operation with multiplier bv takes.
    function automatic int op_len(input int bv);
        int hi;
        if (!EE) return WIDTH;
        hi = 0;
        for (int i = 0; i < WIDTH; i++)
            if (bv[i]) hi = i + 1;
        return (hi == 0) ? 1 : hi;
    endfunction

    // Reference model: operation progress expressed as steps taken.
    bit m_active, m_busy, m_done;
    int m_k, m_len, m_a, m_b, m_prod;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
            m_k <= 0; m_len <= 0; m_a <= 0; m_b <= 0; m_prod <= 0;
        end else if (!m_active) begin
            m_done <= 1'b0;
            if (start) begin
                m_active <= 1'b1;
                m_busy   <= 1'b1;
                m_k      <= 0;
                m_a      <= int'(a);
                m_b      <= int'(b);
                m_len    <= op_len(int'(b));
            end else begin
                m_busy   <= 1'b0;
            end
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_len) begin
                m_active <= 1'b0;
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_prod   <= (m_a * m_b) & MASK;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("product", product, m_prod);
        chk("adder_in0", adder_in0, (m_a * (m_b % (1 << m_k))) & MASK);
        chk("adder_in1", adder_in1, (m_a << m_k) & MASK);
    end

    // Present operands with start for exactly one edge.
    // Returns one time unit after the accept edge.
    task automatic accept(input int av, input int bv);
        @(posedge clk); #1;
        start = 1'b1; a = av[WIDTH-1:0]; b = bv[WIDTH-1:0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count negedges until done is seen (bounded).
    // lat stays 0 if done never arrives.
    task automatic wait_done(output int lat, output int prod);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        prod = -1;
        for (int i = 1; i <= 40; i++) begin
            if (!seen) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    lat  = i;
                    prod = int'(product);
                end
            end
        end
    endtask

    // Count done pulses over n cycles.
    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, prod, cnt, av, bv;
        bit b2b;

        // Reset: all outputs and adder operands are zero.
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset product", product, 0);
        chk("reset adder_in0", adder_in0, 0);
        chk("reset adder_in1", adder_in1, 0);

        // Basic: 5 * 3. The multiplicand doubles each step.
        accept(5, 3);
        @(negedge clk);
        chk("basic busy", busy, 1);
        chk("basic in1 step1", adder_in1, 5);
        @(negedge clk);
        chk("basic in1 step2", adder_in1, 10);
        wait_done(lat, prod);
        chk("basic latency", lat + 2, LAT_B3);
        chk("basic product", prod, 15);

        // Corner operands.
        accept(15, 15); wait_done(lat, prod);
        chk("15x15 product", prod, 225);
        chk("15x15 latency", lat, LAT_FULL);
        accept(0, 15); wait_done(lat, prod);
        chk("0x15 product", prod, 0);
        chk("0x15 latency", lat, LAT_FULL);
        accept(15, 0); wait_done(lat, prod);
        chk("15x0 product", prod, 0);
        chk("15x0 latency", lat, LAT_B0);

        // Short multipliers: these finish early only when the macro is defined.
        accept(9, 1); wait_done(lat, prod);
        chk("9x1 product", prod, 9);
        chk("9x1 latency", lat, LAT_B1);
        accept(9, 4); wait_done(lat, prod);
        chk("9x4 product", prod, 36);
        chk("9x4 latency", lat, LAT_B4);

        // Back-to-back: start held high, new operands presented at the DONE edge.
        @(posedge clk); #1;
        start = 1'b1; a = 4'd6; b = 4'd7;
        @(posedge clk); #1;
        wait_done(lat, prod);
        chk("b2b first product", prod, 42);
        chk("b2b first latency", lat, LAT_B7);
        a = 4'd3; b = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, prod);
        chk("b2b second product", prod, 12);
        chk("b2b done spacing", lat, LAT_B4);

        // A start pulse during RUN is ignored.
        accept(9, 2);
        @(posedge clk); #1;
        start = 1'b1; a = 4'd1; b = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, prod);
        chk("ignore product", prod, 18);
        chk("ignore latency", lat, LAT_IGN);
        count_dones(8, cnt);
        chk("ignore extra done", cnt, 0);

        // Reset in the middle of an operation.
        accept(7, 9);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset product", product, 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        count_dones(8, cnt);
        chk("midreset no done", cnt, 0);

        // Random operations, some launched back-to-back from the DONE cycle.
        b2b = 1'b0;
        for (int n = 0; n < 80; n++) begin
            av = int'($urandom_range(0, (1 << WIDTH) - 1));
            bv = int'($urandom_range(0, (1 << WIDTH) - 1));
            if (b2b) begin
                start = 1'b1; a = av[WIDTH-1:0]; b = bv[WIDTH-1:0];
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                accept(av, bv);
            end
            wait_done(lat, prod);
            chk("random product", prod, av * bv);
            chk("random latency", lat, op_len(bv) + 1);
            b2b = ($urandom_range(0, 1) == 1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
